hazard_stall_unit: RTL and testbench

Scoreboard-based interlock for the two-slot (R ALU slot, S load/store slot) VLIW pipeline. It is the stall side of operand bypassing: it tracks which destination registers are not yet forwardable and holds the ID stage whenever a consumer cannot be served by the EX/MEM or MEM/WB forwarding paths. Those cases are load-use, multi-cycle multiply results, WAW on slow results, and a busy multiplier. It sits beside the ID/EX pipeline register and drives the IF/ID hold and ID/EX bubble.

---
 rtl/vliw_hazard_pkg.sv | 17 +
 rtl/hazard_stall_unit_sb_entry.sv | 39 +++
 rtl/hazard_stall_unit.sv | 115 +++++++++++
 tb/tb_hazard_stall_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_hazard_pkg.sv
// rtl/vliw_hazard_pkg.sv - shared widths, latencies and helpers for the VLIW hazard interlock
package vliw_hazard_pkg;

    localparam int REG_W    = 3;   // register specifier width
    localparam int NREG     = 8;   // architectural registers per file
    localparam int LOAD_LAT = 1;   // load issue -> forwardable
    localparam int MUL_LAT  = 3;   // multiply issue -> forwardable (1..7)
    localparam int CNT_W    = 3;   // scoreboard counter width
    localparam int SCNT_W   = 16;  // stall statistics counter width

    // Larger of two pending latencies; used when both slots target one register.
    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sb_entry.sv
// rtl/hazard_stall_unit_sb_entry.sv - one scoreboard counter: cycles until a register is forwardable
//
// Ports:
//   clk, rst_n   pipeline clock, asynchronous active-low reset
//   r_wr, r_val  R-slot issue write of this register and its new latency
//   s_wr, s_val  S-slot issue write of this register and its new latency
//   cnt          current remaining cycles (0 = served by forwarding / register file)
//   busy         cnt is nonzero
module sb_entry
    import vliw_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_wr,
    input  logic [CNT_W-1:0] r_val,
    input  logic             s_wr,
    input  logic [CNT_W-1:0] s_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    // An issue write replaces the decrement for this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (r_wr && s_wr) begin
            cnt <= cnt_max(r_val, s_val);
        end else if (r_wr) begin
            cnt <= r_val;
        end else if (s_wr) begin
            cnt <= s_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - scoreboard interlock holding ID when forwarding cannot serve a consumer
//
// Ports:
//   clk, rst_n                  pipeline clock, asynchronous active-low reset
//   id_valid, id_flush          ID bundle valid; ID bundle killed by a branch
//   id_rm, id_rn, id_sm, id_sn  R and S slot source registers
//   id_sd, id_s_store           store-data register, live when the S op is a store
//   id_r_we, id_r_mul, id_r_dst R slot writes a register / is a multiply / destination
//   id_s_load, id_s_dst         S slot is a load / load destination
//   stall                       hold IF/ID, bubble into ID/EX
//   mul_busy                    multiplier occupied
//   busy_vec                    per-register "not yet forwardable" flags
//   stall_count                 saturating count of stalled cycles
module hazard_stall_unit
    import vliw_hazard_pkg::*;
#(
    parameter int NREG_P     = NREG,
    parameter int MUL_LAT_P  = MUL_LAT,
    parameter int LOAD_LAT_P = LOAD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_flush,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_sm,
    input  logic [REG_W-1:0]  id_sn,
    input  logic [REG_W-1:0]  id_sd,
    input  logic              id_s_store,
    input  logic              id_r_we,
    input  logic              id_r_mul,
    input  logic [REG_W-1:0]  id_r_dst,
    input  logic              id_s_load,
    input  logic [REG_W-1:0]  id_s_dst,
    output logic              stall,
    output logic              mul_busy,
    output logic [NREG_P-1:0] busy_vec,
    output logic [SCNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] MUL_C  = CNT_W'(MUL_LAT_P);
    localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT_P);

    logic [NREG_P-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]             mul_cnt;

    logic             r_wr_en, s_wr_en;
    logic [CNT_W-1:0] r_new;
    logic             raw_hit, sd_hit, waw_hit, mul_hit;
    logic             issue;

    // Register 0 is hard-wired to zero and never tracked.
    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    assign r_wr_en = id_r_we && (id_r_dst != '0);
    assign s_wr_en = id_s_load && (id_s_dst != '0);
    assign r_new   = id_r_mul ? MUL_C : '0;

    assign raw_hit = ((id_rm != '0) && (cnt[id_rm] != '0))
                  || ((id_rn != '0) && (cnt[id_rn] != '0))
                  || ((id_sm != '0) && (cnt[id_sm] != '0))
                  || ((id_sn != '0) && (cnt[id_sn] != '0));

    // A count of 1 is covered by the load-to-store bypass in MEM.
    assign sd_hit  = id_s_store && (id_sd != '0) && (cnt[id_sd] > CNT_W'(1));

    // A newer write must not complete before an older, slower one.
    assign waw_hit = (r_wr_en && (cnt[id_r_dst] > r_new))
                  || (s_wr_en && (cnt[id_s_dst] > LOAD_C));

    // The multiplier can accept a new op once the previous one is in its last cycle.
    assign mul_hit = id_r_mul && (mul_cnt > CNT_W'(1));

    assign stall = id_valid && !id_flush && (raw_hit || sd_hit || waw_hit || mul_hit);
    assign issue = id_valid && !id_flush && !stall;

    genvar gi;
    generate
        for (gi = 1; gi < NREG_P; gi++) begin : g_sb
            sb_entry u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .r_wr  (issue && r_wr_en && (id_r_dst == REG_W'(gi))),
                .r_val (r_new),
                .s_wr  (issue && s_wr_en && (id_s_dst == REG_W'(gi))),
                .s_val (LOAD_C),
                .cnt   (cnt[gi]),
                .busy  (busy_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (issue && id_r_mul) begin
            mul_cnt <= MUL_C;
        end else if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - 1'b1;
        end
    end

    assign mul_busy = (mul_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {SCNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    localparam int ML = 3;
    localparam int LL = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_flush;
    logic [2:0]  id_rm, id_rn, id_sm, id_sn, id_sd, id_r_dst, id_s_dst;
    logic        id_s_store, id_r_we, id_r_mul, id_s_load;
    logic        stall, mul_busy;
    logic [7:0]  busy_vec;
    logic [15:0] stall_count;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int mc [8];
    int mm;
    int sc;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
        .id_rm(id_rm), .id_rn(id_rn), .id_sm(id_sm), .id_sn(id_sn), .id_sd(id_sd),
        .id_s_store(id_s_store), .id_r_we(id_r_we), .id_r_mul(id_r_mul),
        .id_r_dst(id_r_dst), .id_s_load(id_s_load), .id_s_dst(id_s_dst),
        .stall(stall), .mul_busy(mul_busy), .busy_vec(busy_vec), .stall_count(stall_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_stall();
        bit s = 0;
        if (!id_valid || id_flush) return 0;
        if (id_rm != 0 && mc[id_rm] > 0) s = 1;
        if (id_rn != 0 && mc[id_rn] > 0) s = 1;
        if (id_sm != 0 && mc[id_sm] > 0) s = 1;
        if (id_sn != 0 && mc[id_sn] > 0) s = 1;
        if (id_s_store && mc[id_sd] > 1) s = 1;
        if (id_r_we && id_r_dst != 0 && mc[id_r_dst] > (id_r_mul ? ML : 0)) s = 1;
        if (id_s_load && id_s_dst != 0 && mc[id_s_dst] > LL) s = 1;
        if (id_r_mul && mm > 1) s = 1;
        return s;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = (mc[i] > 0);
        return b;
    endfunction

    // Model advance on each clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mc[i] = 0;
            mm = 0;
            sc = 0;
        end else begin
            bit st, iss;
            int nc [8];
            int rv;
            st  = m_stall();
            iss = id_valid && !id_flush && !st;
            for (int i = 0; i < 8; i++) nc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
            rv = id_r_mul ? ML : 0;
            if (iss && id_r_we && id_r_dst != 0) nc[id_r_dst] = rv;
            if (iss && id_s_load && id_s_dst != 0) begin
                if (id_r_we && id_r_dst == id_s_dst) nc[id_s_dst] = (rv > LL) ? rv : LL;
                else nc[id_s_dst] = LL;
            end
            nc[0] = 0;
            for (int i = 0; i < 8; i++) mc[i] = nc[i];
            if (iss && id_r_mul) mm = ML;
            else if (mm > 0) mm = mm - 1;
            if (st && sc < 65535) sc = sc + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", {31'b0, stall}, {31'b0, m_stall()});
            chk("mul_busy", {31'b0, mul_busy}, {31'b0, mm != 0});
            chk("busy_vec", {24'b0, busy_vec}, {24'b0, m_busy()});
            chk("stall_count", {16'b0, stall_count}, sc[31:0]);
        end
    end

    task automatic idle();
        id_valid = 0; id_flush = 0;
        id_rm = 0; id_rn = 0; id_sm = 0; id_sn = 0; id_sd = 0;
        id_s_store = 0; id_r_we = 0; id_r_mul = 0; id_r_dst = 0;
        id_s_load = 0; id_s_dst = 0;
    endtask

    task automatic clr();
        idle();
        id_valid = 1;
    endtask

    task automatic gap();
        idle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Hold the current bundle until it issues; count its stall cycles.
    task automatic send(input string nm, input int exp_st);
        int n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk(nm, n, exp_st);
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_mul_busy", {31'b0, mul_busy}, 0);
        chk("rst_busy_vec", {24'b0, busy_vec}, 0);
        chk("rst_stall_count", {16'b0, stall_count}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Load-use at distance 1
        clr(); id_s_load = 1; id_s_dst = 3;
        send("ld_r3", 0);
        chk("busy_vec_after_ld", {24'b0, busy_vec}, 32'h08);
        clr(); id_rm = 3;
        send("ld_use_stalls", 1);
        chk("busy_vec_cleared", {24'b0, busy_vec}, 0);
        chk("cnt_after_lduse", {16'b0, stall_count}, 1);

        // Load-use at distance 2
        clr(); id_s_load = 1; id_s_dst = 3;
        send("ld_r3_b", 0);
        clr();
        send("filler", 0);
        clr(); id_rn = 3;
        send("ld_use_d2", 0);
        gap();

        // Multiply then dependent in id_sn
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 5;
        send("mul_r5", 0);
        chk("mul_busy_set", {31'b0, mul_busy}, 1);
        clr(); id_sn = 5;
        send("mul_use_stalls", 3);
        chk("mul_busy_done", {31'b0, mul_busy}, 0);
        chk("cnt_after_mul", {16'b0, stall_count}, 4);
        gap();

        // Load then store of the loaded register
        clr(); id_s_load = 1; id_s_dst = 4;
        send("ld_r4", 0);
        clr(); id_s_store = 1; id_sd = 4;
        send("ld_st_nostall", 0);
        gap();

        // Multiply then store of the product
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 4;
        send("mul_r4", 0);
        clr(); id_s_store = 1; id_sd = 4;
        send("mul_st_stalls", 2);
        gap();

        // Back-to-back independent multiplies
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 1;
        send("mul_r1", 0);
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 7;
        send("mul_busy_stalls", 2);
        gap();

        // WAW on a pending multiply result
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 2;
        send("mul_r2", 0);
        clr(); id_r_we = 1; id_r_dst = 2;
        send("waw_stalls", 3);
        gap();

        // Register 0 never stalls
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 0;
        send("mul_r0", 0);
        clr(); id_r_we = 1; id_r_dst = 0; id_s_load = 1; id_s_dst = 0;
        id_s_store = 1; id_sd = 0;
        send("r0_nostall", 0);
        gap();

        // Flush during a pending stall
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 5;
        send("mul_r5_b", 0);
        clr(); id_sn = 5; id_flush = 1;
        @(negedge clk);
        chk("flush_no_stall", {31'b0, stall}, 0);
        @(posedge clk); #1;
        id_flush = 0;
        send("post_flush_stalls", 2);
        gap();

        // Saturation of stall_count
        force dut.stall_count = 16'hFFFE;
        #1;
        release dut.stall_count;
        sc = 32'hFFFE;
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 5;
        send("mul_r5_c", 0);
        clr(); id_sn = 5;
        send("sat_stalls", 3);
        chk("stall_count_sat", {16'b0, stall_count}, 32'hFFFF);
        gap();

        // Reset mid-stall
        clr(); id_r_we = 1; id_r_mul = 1; id_r_dst = 6;
        send("mul_r6", 0);
        clr(); id_rm = 6;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_stall", {31'b0, stall}, 1);
        chk("pre_rst_busy_vec", {24'b0, busy_vec}, 32'h40);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 0);
        chk("mid_rst_mul_busy", {31'b0, mul_busy}, 0);
        chk("mid_rst_busy_vec", {24'b0, busy_vec}, 0);
        chk("mid_rst_stall_count", {16'b0, stall_count}, 0);
        idle();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
